// File: rtl/pcie_mailbox_if.sv
// Avalon-MM slave bus plus the two Avalon-ST stream links and the interrupt line of the mailbox.
// The slave modport is the mailbox's view; the master modport is the host/core side.
interface pcie_mailbox_if #(
    parameter int unsigned DATA_W = 32
);
    logic [1:0]        avs_address;
    logic              avs_write;
    logic [DATA_W-1:0] avs_writedata;
    logic              avs_read;
    logic [DATA_W-1:0] avs_readdata;

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    logic              irq;

    modport slave (
        input  avs_address, avs_write, avs_writedata, avs_read, out_ready, in_data, in_valid,
        output avs_readdata, out_data, out_valid, in_ready, irq
    );

    modport master (
        output avs_address, avs_write, avs_writedata, avs_read, out_ready, in_data, in_valid,
        input  avs_readdata, out_data, out_valid, in_ready, irq
    );
endinterface

// File: rtl/pcie_mailbox.sv
// Host/accelerator mailbox: inbound FIFO (host writes -> ST source), outbound FIFO
// (ST sink -> host reads), sticky OVF/UNF flags and a registered level interrupt.
module pcie_mailbox #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pcie_mailbox_if.slave        bus
);
    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DepthCnt = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    logic [DATA_W-1:0] in_mem_q  [Depth];
    logic [DATA_W-1:0] in_mem_d  [Depth];
    logic [DATA_W-1:0] out_mem_q [Depth];
    logic [DATA_W-1:0] out_mem_d [Depth];

    ptr_t in_wptr_q, in_wptr_d, in_rptr_q, in_rptr_d;
    ptr_t out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;
    cnt_t in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;

    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              irq_en_q, irq_en_d;
    logic              irq_q, irq_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic in_full, out_empty;
    logic in_push, in_pop, out_push, out_pop;
    logic ctrl_wr, flush, clr_err, ovf_evt, unf_evt, rd_out;
    logic unused_wdata;

    assign unused_wdata = ^bus.avs_writedata[30:2];

    // All decisions use pre-cycle state, so a push to a full FIFO is dropped even if it pops.
    always_comb begin
        in_full   = (in_cnt_q == DepthCnt);
        out_empty = (out_cnt_q == '0);
        ctrl_wr   = bus.avs_write && (bus.avs_address == 2'd3);
        flush     = ctrl_wr && bus.avs_writedata[0];
        clr_err   = ctrl_wr && bus.avs_writedata[1];
        in_push   = bus.avs_write && (bus.avs_address == 2'd0) && !in_full;
        ovf_evt   = bus.avs_write && (bus.avs_address == 2'd0) && in_full;
        in_pop    = (in_cnt_q != '0) && bus.out_ready;
        out_push  = bus.in_valid && (out_cnt_q != DepthCnt);
        rd_out    = bus.avs_read && (bus.avs_address == 2'd1);
        out_pop   = rd_out && !out_empty;
        unf_evt   = rd_out && out_empty;
    end

    always_comb begin
        in_mem_d   = in_mem_q;
        out_mem_d  = out_mem_q;
        in_wptr_d  = in_wptr_q;
        in_rptr_d  = in_rptr_q;
        in_cnt_d   = in_cnt_q;
        out_wptr_d = out_wptr_q;
        out_rptr_d = out_rptr_q;
        out_cnt_d  = out_cnt_q;

        if (flush) begin
            in_wptr_d  = '0;
            in_rptr_d  = '0;
            in_cnt_d   = '0;
            out_wptr_d = '0;
            out_rptr_d = '0;
            out_cnt_d  = '0;
        end else begin
            if (in_push) begin
                in_mem_d[in_wptr_q] = bus.avs_writedata;
                in_wptr_d           = in_wptr_q + 1'b1;
            end
            if (in_pop) begin
                in_rptr_d = in_rptr_q + 1'b1;
            end
            case ({in_push, in_pop})
                2'b10:   in_cnt_d = in_cnt_q + 1'b1;
                2'b01:   in_cnt_d = in_cnt_q - 1'b1;
                default: in_cnt_d = in_cnt_q;
            endcase

            if (out_push) begin
                out_mem_d[out_wptr_q] = bus.in_data;
                out_wptr_d            = out_wptr_q + 1'b1;
            end
            if (out_pop) begin
                out_rptr_d = out_rptr_q + 1'b1;
            end
            case ({out_push, out_pop})
                2'b10:   out_cnt_d = out_cnt_q + 1'b1;
                2'b01:   out_cnt_d = out_cnt_q - 1'b1;
                default: out_cnt_d = out_cnt_q;
            endcase
        end
    end

    always_comb begin
        // A new error event beats a simultaneous clear.
        ovf_d    = (ovf_q && !clr_err) || ovf_evt;
        unf_d    = (unf_q && !clr_err) || unf_evt;
        irq_en_d = ctrl_wr ? bus.avs_writedata[31] : irq_en_q;
        irq_d    = irq_en_q && !out_empty;
        rdata_d  = rdata_q;
        if (bus.avs_read) begin
            unique case (bus.avs_address)
                2'd0: rdata_d = '0;
                2'd1: rdata_d = out_empty ? '0 : out_mem_q[out_rptr_q];
                2'd2: rdata_d = {irq_en_q, 5'b0, unf_q, ovf_q, 6'b0, out_empty, in_full,
                                 8'(out_cnt_q), 8'(in_cnt_q)};
                2'd3: rdata_d = {irq_en_q, 31'b0};
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_wptr_q  <= '0;
            in_rptr_q  <= '0;
            in_cnt_q   <= '0;
            out_wptr_q <= '0;
            out_rptr_q <= '0;
            out_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            in_wptr_q  <= in_wptr_d;
            in_rptr_q  <= in_rptr_d;
            in_cnt_q   <= in_cnt_d;
            out_wptr_q <= out_wptr_d;
            out_rptr_q <= out_rptr_d;
            out_cnt_q  <= out_cnt_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
        end
        in_mem_q  <= in_mem_d;
        out_mem_q <= out_mem_d;
    end

    assign bus.avs_readdata = rdata_q;
    assign bus.out_data     = in_mem_q[in_rptr_q];
    assign bus.out_valid    = (in_cnt_q != '0);
    assign bus.in_ready     = (out_cnt_q != DepthCnt);
    assign bus.irq          = irq_q;
endmodule

// File: tb/tb_pcie_mailbox.sv
// Directed bench for pcie_mailbox: hand-computed expectations checked with immediate assertions.
module tb_pcie_mailbox;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fails;

    pcie_mailbox_if #(.DATA_W(32)) bus ();

    pcie_mailbox #(.DEPTH_LOG2(4), .DATA_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic host_write(input logic [1:0] addr, input logic [31:0] data);
        bus.avs_address   = addr;
        bus.avs_writedata = data;
        bus.avs_write     = 1'b1;
        step();
        bus.avs_write     = 1'b0;
    endtask

    task automatic host_read(input logic [1:0] addr, output logic [31:0] data);
        bus.avs_address = addr;
        bus.avs_read    = 1'b1;
        step();
        bus.avs_read    = 1'b0;
        data            = bus.avs_readdata;
    endtask

    logic [31:0] rd;

    initial begin
        n_checks          = 0;
        n_fails           = 0;
        reset_n           = 1'b0;
        bus.avs_address   = '0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;
        bus.avs_read      = 1'b0;
        bus.out_ready     = 1'b0;
        bus.in_data       = '0;
        bus.in_valid      = 1'b0;
        step();
        step();
        chk("rst_readdata", bus.avs_readdata, 32'h0);
        reset_n = 1'b1;

        // Reset state
        host_read(2'd2, rd);
        chk("rst_status", rd, 32'h0002_0000);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("rst_irq", {31'b0, bus.irq}, 32'h0);

        // Three inbound words, then drain in order
        for (int i = 1; i <= 3; i++) host_write(2'd0, 32'hA5A5_0000 + i);
        host_read(2'd2, rd);
        chk("in3_status", rd, 32'h0002_0003);
        chk("in3_head", bus.out_data, 32'hA5A5_0001);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            chk("in3_valid", {31'b0, bus.out_valid}, 32'h1);
            chk("in3_data", bus.out_data, 32'hA5A5_0000 + i);
            step();
        end
        chk("in3_drained", {31'b0, bus.out_valid}, 32'h0);
        bus.out_ready = 1'b0;

        // Overflow: 17 writes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) host_write(2'd0, 32'hB000_0000 + i);
        host_read(2'd2, rd);
        chk("ovf_status", rd, 32'h0103_0010);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("ovf_data", bus.out_data, 32'hB000_0000 + i);
            step();
        end
        chk("ovf_17th_absent", {31'b0, bus.out_valid}, 32'h0);
        bus.out_ready = 1'b0;
        host_write(2'd3, 32'h0000_0002);
        host_read(2'd2, rd);
        chk("ovf_cleared", rd, 32'h0002_0000);

        // Interrupt and underflow
        host_write(2'd3, 32'h8000_0000);
        bus.in_data  = 32'h1234_5678;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("irq_lag", {31'b0, bus.irq}, 32'h0);
        step();
        chk("irq_set", {31'b0, bus.irq}, 32'h1);
        host_read(2'd1, rd);
        chk("irq_read", rd, 32'h1234_5678);
        step();
        chk("irq_fall", {31'b0, bus.irq}, 32'h0);
        host_read(2'd1, rd);
        chk("unf_read", rd, 32'h0);
        host_read(2'd2, rd);
        chk("unf_status", rd, 32'h8202_0000);
        host_read(2'd3, rd);
        chk("ctrl_read", rd, 32'h8000_0000);
        host_write(2'd3, 32'h0000_0002);
        host_read(2'd2, rd);
        chk("unf_cleared", rd, 32'h0002_0000);

        // Outbound full: read and blocked push in the same cycle
        bus.in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.in_data = 32'hC000_0000 + i;
            step();
        end
        chk("out_full_ready", {31'b0, bus.in_ready}, 32'h0);
        bus.in_data = 32'hDEAD_BEEF;
        host_read(2'd1, rd);
        bus.in_valid = 1'b0;
        chk("out_full_oldest", rd, 32'hC000_0000);
        chk("out_full_reopen", {31'b0, bus.in_ready}, 32'h1);
        host_read(2'd2, rd);
        chk("out_full_cnt15", rd, 32'h0000_0F00);
        for (int i = 1; i < 16; i++) begin
            host_read(2'd1, rd);
            chk("out_drain", rd, 32'hC000_0000 + i);
        end
        host_read(2'd2, rd);
        chk("out_no_extra", rd, 32'h0002_0000);

        // Flush beats same-cycle transfers on both FIFOs
        for (int i = 0; i < 5; i++) host_write(2'd0, 32'hD000_0000 + i);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = 32'hE000_0000 + i;
            step();
        end
        bus.in_valid = 1'b0;
        host_read(2'd2, rd);
        chk("pre_flush_status", rd, 32'h0000_0505);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hF000_0000;
        host_write(2'd3, 32'h0000_0001);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("flush_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("flush_in_ready", {31'b0, bus.in_ready}, 32'h1);
        host_read(2'd2, rd);
        chk("flush_status", rd, 32'h0002_0000);
        host_read(2'd1, rd);
        chk("flush_no_word", rd, 32'h0);

        // Push into empty FIFO is visible only on the next cycle
        host_read(2'd2, rd);
        bus.avs_address   = 2'd0;
        bus.avs_writedata = 32'h7777_0001;
        bus.avs_write     = 1'b1;
        #1;
        chk("push_not_same_cycle", {31'b0, bus.out_valid}, 32'h0);
        step();
        bus.avs_write = 1'b0;
        chk("push_next_cycle", {31'b0, bus.out_valid}, 32'h1);
        chk("push_next_data", bus.out_data, 32'h7777_0001);

        // Mid-operation reset discards contents
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("mid_rst_valid", {31'b0, bus.out_valid}, 32'h0);
        host_read(2'd2, rd);
        chk("mid_rst_status", rd, 32'h0002_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
